imem_loader: RTL and testbench

Byte-stream program loader that writes a framed program image into the CPU's instruction memory and holds the CPU in reset until the image is verified. It is the writer for the CPU's instruction-fetch reader. It sits between a byte source (UART receiver or bench driver) and the instruction-memory write port, and drives the `cpu` reset input. On a good checksum it releases the CPU, so the existing execute-until-HALT flow runs on freshly loaded code.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader.sv | 116 +++++++++++
 tb/tb_imem_loader.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the program loader
package imem_loader_pkg;

   typedef enum logic [2:0] {
      WAIT_HDR,
      LEN,
      DATA,
      CSUM,
      RUN,
      ERR
   } state_t;

   localparam logic [7:0] LOADER_HDR = 8'hA5;
   localparam int         CSUM_W     = 8;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader into instruction memory, holds the CPU in reset until the image checks out
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   output logic              s_ready,
   input  logic              reload,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              cpu_rst,
   output logic              done,
   output logic              err,
   output logic [7:0]        prog_len
);

   localparam logic [31:0] CAP = 32'd1 << ADDR_W;

   state_t              state;
   state_t              state_nxt;
   logic [7:0]          len_q;
   logic [ADDR_W-1:0]   idx;
   logic [CSUM_W-1:0]   sum;
   logic                xfer;
   logic                len_bad;
   logic                last_byte;

   assign xfer      = s_valid & s_ready;
   assign len_bad   = (s_data == 8'd0) || ({24'd0, s_data} > CAP);
   assign last_byte = (32'(idx) == ({24'd0, len_q} - 32'd1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= WAIT_HDR;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (reload) begin
         state_nxt = WAIT_HDR;
      end else if (xfer) begin
         case (state)
            WAIT_HDR: if (s_data == LOADER_HDR) state_nxt = LEN;
            LEN:      state_nxt = len_bad ? ERR : DATA;
            DATA:     if (last_byte) state_nxt = CSUM;
            CSUM:     state_nxt = (s_data == sum) ? RUN : ERR;
            default:  state_nxt = state;
         endcase
      end
   end

   // reload masks the handshake so a byte offered in the same cycle is not consumed
   always_comb begin
      s_ready = 1'b0;
      cpu_rst = 1'b1;
      done    = 1'b0;
      err     = 1'b0;
      case (state)
         WAIT_HDR, LEN, DATA, CSUM: s_ready = !reload;
         RUN: begin
            cpu_rst = reload;
            done    = !reload;
         end
         ERR:     err = !reload;
         default: s_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= 8'd0;
         prog_len  <= 8'd0;
         len_q     <= 8'd0;
         idx       <= '0;
         sum       <= '0;
      end else begin
         mem_we <= 1'b0;
         if (reload) begin
            idx <= '0;
            sum <= '0;
         end else if (xfer) begin
            case (state)
               LEN: begin
                  if (!len_bad) begin
                     len_q <= s_data;
                     idx   <= '0;
                     sum   <= '0;
                  end
               end
               DATA: begin
                  mem_we    <= 1'b1;
                  mem_addr  <= idx;
                  mem_wdata <= s_data;
                  sum       <= sum + s_data;
                  idx       <= idx + ADDR_W'(1);
               end
               CSUM: begin
                  if (s_data == sum) prog_len <= len_q;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

   typedef struct {
      logic       rst;
      logic       v;
      logic [7:0] d;
      logic       rl;
      logic       we;
      logic [7:0] ad;
      logic [7:0] wd;
      logic       rdy;
      logic       crst;
      logic       dn;
      logic       er;
      logic [7:0] pl;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       s_valid = 1'b0;
   logic [7:0] s_data = 8'd0;
   logic       s_ready;
   logic       reload = 1'b0;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       cpu_rst;
   logic       done;
   logic       err;
   logic [7:0] prog_len;

   int checks = 0;
   int failures = 0;
   logic [15:0] wr_log[$];

   imem_loader #(.ADDR_W(8)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .reload(reload), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_rst(cpu_rst), .done(done), .err(err), .prog_len(prog_len)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (mem_we) wr_log.push_back({mem_addr, mem_wdata});

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d, input logic rl,
                               input logic we, input logic [7:0] ad, input logic [7:0] wd,
                               input logic rdy, input logic crst, input logic dn, input logic er,
                               input logic [7:0] pl);
      vec_t t;
      t.rst = r; t.v = v; t.d = d; t.rl = rl;
      t.we = we; t.ad = ad; t.wd = wd; t.rdy = rdy; t.crst = crst; t.dn = dn; t.er = er; t.pl = pl;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic put(input logic [7:0] b);
      bit ok = 0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      s_valid = 1'b1;
      s_data  = b;
      for (int i = 0; i < 8; i++) begin
         if (s_ready) begin
            @(posedge clk);
            ok = 1;
            break;
         end
         @(posedge clk);
         #1;
      end
      #1;
      s_valid = 1'b0;
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL put_accept: byte %h actual=not_accepted required=accepted", b);
      end
   endtask

   vec_t vecs[$];
   logic [39:0] act_o;
   logic [39:0] exp_o;

   initial begin
      // reset
      vecs.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 8'h00));
      // good frame A5 03 11 22 33 66
      vecs.push_back(mk(0, 1, 8'hA5, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 8'h00));
      vecs.push_back(mk(0, 1, 8'h03, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 8'h00));
      vecs.push_back(mk(0, 1, 8'h11, 0, 1, 8'h00, 8'h11, 1, 1, 0, 0, 8'h00));
      vecs.push_back(mk(0, 1, 8'h22, 0, 1, 8'h01, 8'h22, 1, 1, 0, 0, 8'h00));
      vecs.push_back(mk(0, 1, 8'h33, 0, 1, 8'h02, 8'h33, 1, 1, 0, 0, 8'h00));
      vecs.push_back(mk(0, 1, 8'h66, 0, 0, 8'h02, 8'h33, 0, 0, 1, 0, 8'h03));
      vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h02, 8'h33, 1, 1, 0, 0, 8'h03));
      // bad checksum A5 02 10 20 00, then a byte offered in ERR
      vecs.push_back(mk(0, 1, 8'hA5, 0, 0, 8'h02, 8'h33, 1, 1, 0, 0, 8'h03));
      vecs.push_back(mk(0, 1, 8'h02, 0, 0, 8'h02, 8'h33, 1, 1, 0, 0, 8'h03));
      vecs.push_back(mk(0, 1, 8'h10, 0, 1, 8'h00, 8'h10, 1, 1, 0, 0, 8'h03));
      vecs.push_back(mk(0, 1, 8'h20, 0, 1, 8'h01, 8'h20, 1, 1, 0, 0, 8'h03));
      vecs.push_back(mk(0, 1, 8'h00, 0, 0, 8'h01, 8'h20, 0, 1, 0, 1, 8'h03));
      vecs.push_back(mk(0, 1, 8'hA5, 0, 0, 8'h01, 8'h20, 0, 1, 0, 1, 8'h03));
      vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h01, 8'h20, 1, 1, 0, 0, 8'h03));
      // zero length, then reload and A5 01 7E 7E
      vecs.push_back(mk(0, 1, 8'hA5, 0, 0, 8'h01, 8'h20, 1, 1, 0, 0, 8'h03));
      vecs.push_back(mk(0, 1, 8'h00, 0, 0, 8'h01, 8'h20, 0, 1, 0, 1, 8'h03));
      vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h01, 8'h20, 1, 1, 0, 0, 8'h03));
      vecs.push_back(mk(0, 1, 8'hA5, 0, 0, 8'h01, 8'h20, 1, 1, 0, 0, 8'h03));
      vecs.push_back(mk(0, 1, 8'h01, 0, 0, 8'h01, 8'h20, 1, 1, 0, 0, 8'h03));
      vecs.push_back(mk(0, 1, 8'h7E, 0, 1, 8'h00, 8'h7E, 1, 1, 0, 0, 8'h03));
      vecs.push_back(mk(0, 1, 8'h7E, 0, 0, 8'h00, 8'h7E, 0, 0, 1, 0, 8'h01));
      vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 8'h7E, 1, 1, 0, 0, 8'h01));
      // leading garbage 00 FF 5A A5 01 42 42
      vecs.push_back(mk(0, 1, 8'h00, 0, 0, 8'h00, 8'h7E, 1, 1, 0, 0, 8'h01));
      vecs.push_back(mk(0, 1, 8'hFF, 0, 0, 8'h00, 8'h7E, 1, 1, 0, 0, 8'h01));
      vecs.push_back(mk(0, 1, 8'h5A, 0, 0, 8'h00, 8'h7E, 1, 1, 0, 0, 8'h01));
      vecs.push_back(mk(0, 1, 8'hA5, 0, 0, 8'h00, 8'h7E, 1, 1, 0, 0, 8'h01));
      vecs.push_back(mk(0, 1, 8'h01, 0, 0, 8'h00, 8'h7E, 1, 1, 0, 0, 8'h01));
      vecs.push_back(mk(0, 1, 8'h42, 0, 1, 8'h00, 8'h42, 1, 1, 0, 0, 8'h01));
      vecs.push_back(mk(0, 1, 8'h42, 0, 0, 8'h00, 8'h42, 0, 0, 1, 0, 8'h01));
      vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 8'h42, 1, 1, 0, 0, 8'h01));
      // reload mid-DATA with a byte offered on the reload cycle
      vecs.push_back(mk(0, 1, 8'hA5, 0, 0, 8'h00, 8'h42, 1, 1, 0, 0, 8'h01));
      vecs.push_back(mk(0, 1, 8'h04, 0, 0, 8'h00, 8'h42, 1, 1, 0, 0, 8'h01));
      vecs.push_back(mk(0, 1, 8'h01, 0, 1, 8'h00, 8'h01, 1, 1, 0, 0, 8'h01));
      vecs.push_back(mk(0, 1, 8'h02, 0, 1, 8'h01, 8'h02, 1, 1, 0, 0, 8'h01));
      vecs.push_back(mk(0, 1, 8'h03, 1, 0, 8'h01, 8'h02, 1, 1, 0, 0, 8'h01));
      vecs.push_back(mk(0, 1, 8'hA5, 0, 0, 8'h01, 8'h02, 1, 1, 0, 0, 8'h01));
      vecs.push_back(mk(0, 1, 8'h01, 0, 0, 8'h01, 8'h02, 1, 1, 0, 0, 8'h01));
      vecs.push_back(mk(0, 1, 8'h09, 0, 1, 8'h00, 8'h09, 1, 1, 0, 0, 8'h01));
      vecs.push_back(mk(0, 1, 8'h09, 0, 0, 8'h00, 8'h09, 0, 0, 1, 0, 8'h01));

      @(posedge clk);
      #1;
      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].rst; s_valid = vecs[i].v; s_data = vecs[i].d; reload = vecs[i].rl;
         @(posedge clk);
         #1;
         rst = 1'b0; s_valid = 1'b0; s_data = 8'h00; reload = 1'b0;
         #1;
         act_o = {mem_we, mem_addr, mem_wdata, s_ready, cpu_rst, done, err, prog_len, 4'h0};
         exp_o = {vecs[i].we, vecs[i].ad, vecs[i].wd, vecs[i].rdy, vecs[i].crst,
                  vecs[i].dn, vecs[i].er, vecs[i].pl, 4'h0};
         checks++;
         if (act_o !== exp_o) begin
            failures++;
            $display("FAIL vec%0d: actual we=%b addr=%h wdata=%h rdy=%b crst=%b done=%b err=%b plen=%h required we=%b addr=%h wdata=%h rdy=%b crst=%b done=%b err=%b plen=%h",
                     i, mem_we, mem_addr, mem_wdata, s_ready, cpu_rst, done, err, prog_len,
                     vecs[i].we, vecs[i].ad, vecs[i].wd, vecs[i].rdy, vecs[i].crst,
                     vecs[i].dn, vecs[i].er, vecs[i].pl);
         end
      end

      // reload while a byte is offered: handshake masked in the same cycle
      reload = 1'b1; s_valid = 1'b1; s_data = 8'hA5;
      #1;
      check("ready_during_reload", 32'(s_ready), 32'd0);
      check("crst_during_reload", 32'(cpu_rst), 32'd1);
      @(posedge clk);
      #1;
      reload = 1'b0; s_valid = 1'b0;
      #1;
      check("crst_after_reload", 32'(cpu_rst), 32'd1);

      // gapped frame A5 02 AA 55 FF
      wr_log.delete();
      put(8'hA5); put(8'h02); put(8'hAA); put(8'h55); put(8'hFF);
      #1;
      check("gap_nwrites", 32'(wr_log.size()), 32'd2);
      if (wr_log.size() == 2) begin
         check("gap_wr0", 32'(wr_log[0]), 32'h00AA);
         check("gap_wr1", 32'(wr_log[1]), 32'h0155);
      end
      check("gap_done", 32'(done), 32'd1);
      check("gap_crst", 32'(cpu_rst), 32'd0);
      check("gap_err", 32'(err), 32'd0);
      check("gap_plen", 32'(prog_len), 32'd2);

      // rst mid-frame with a write in flight
      @(posedge clk);
      #1;
      reload = 1'b1;
      @(posedge clk);
      #1;
      reload = 1'b0;
      put(8'hA5); put(8'h02); put(8'hAA);
      check("inflight_we", 32'(mem_we), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      check("rst_wdata", 32'(mem_wdata), 32'd0);
      check("rst_plen", 32'(prog_len), 32'd0);
      check("rst_flags", {29'd0, cpu_rst, done, err}, 32'b100);
      check("rst_ready", 32'(s_ready), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
